// File: rtl/i2c_pkg.sv
// i2c_pkg: command codes and FSM states shared by the OLED I2C master.
package i2c_pkg;

  typedef enum logic [2:0] {
    I2C_NOP     = 3'd0,
    I2C_START   = 3'd1,
    I2C_STOP    = 3'd2,
    I2C_SENDCON = 3'd3,
    I2C_SENDI2C = 3'd4
  } i2c_cmd_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_BIT,
    S_ACK,
    S_STOP,
    S_DONE
  } i2c_state_e;

  function automatic logic is_send(input logic [2:0] c);
    return (c == I2C_SENDCON) || (c == I2C_SENDI2C);
  endfunction

endpackage

// File: rtl/i2c_quarter_tick.sv
// i2c_quarter_tick: free-running divider, one-cycle tick every CLK_DIV
// cycles while enabled; a clear restarts the phase from zero.
module i2c_quarter_tick #(
  parameter int CLK_DIV = 30
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign tick = en && !clr && (cnt == LAST);

endmodule

// File: rtl/i2c_oled_master.sv
// i2c_oled_master: executes one I2C bus primitive per core command
// (START, STOP, address byte, data byte) on open-drain SCL/SDA.
module i2c_oled_master
  import i2c_pkg::*;
#(
  parameter int         CLK_DIV    = 30,
  parameter logic [6:0] SLAVE_ADDR = 7'h3C
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [2:0] i_cmd,
  input  logic       i_cmd_valid,
  input  logic [7:0] i_data,
  input  logic       i_sda,
  output logic       o_scl_oe,
  output logic       o_sda_oe,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_nack,
  output logic       o_err
);

  i2c_state_e state;
  logic [1:0] q;
  logic [2:0] bit_idx;
  logic [6:0] shreg;
  logic       bus_open;
  logic       tick;
  logic       accept;
  logic       legal;
  logic [7:0] load_byte;

  // Codes 101..111 fall outside the accepted range and act as no-ops.
  assign accept = i_cmd_valid && !o_busy && !o_done &&
                  (i_cmd != I2C_NOP) && (i_cmd <= I2C_SENDI2C);

  assign legal = (i_cmd == I2C_START) || bus_open;

  assign load_byte = (i_cmd == I2C_SENDCON) ?
                     {SLAVE_ADDR, 1'b0} : i_data;

  i2c_quarter_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk  (i_clk),
    .rst_n(i_rst_n),
    .clr  (accept),
    .en   (o_busy),
    .tick (tick)
  );

  // Line levels are registered for the phase being entered, so each
  // quarter's outputs hold for its full CLK_DIV cycles.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state    <= S_IDLE;
      q        <= 2'd0;
      bit_idx  <= 3'd0;
      shreg    <= 7'd0;
      bus_open <= 1'b0;
      o_scl_oe <= 1'b0;
      o_sda_oe <= 1'b0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_nack   <= 1'b0;
      o_err    <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (accept) begin
        q     <= 2'd0;
        o_err <= !legal;
        if (is_send(i_cmd)) begin
          o_nack <= 1'b0;
        end
        if (!legal) begin
          o_done <= 1'b1;
          state  <= S_DONE;
        end else begin
          o_busy <= 1'b1;
          unique case (1'b1)
            (i_cmd == I2C_START): begin
              state    <= S_START;
              o_sda_oe <= 1'b0;
            end
            (i_cmd == I2C_STOP): begin
              state    <= S_STOP;
              o_scl_oe <= 1'b1;
              o_sda_oe <= 1'b1;
            end
            default: begin
              state    <= S_BIT;
              bit_idx  <= 3'd7;
              shreg    <= load_byte[6:0];
              o_scl_oe <= 1'b1;
              o_sda_oe <= ~load_byte[7];
            end
          endcase
        end
      end else if (state == S_DONE) begin
        state <= S_IDLE;
      end else if (tick) begin
        q <= q + 2'd1;
        unique case (state)
          S_START: begin
            unique case (q)
              2'd0: o_scl_oe <= 1'b0;
              2'd1: o_sda_oe <= 1'b1;
              2'd2: o_scl_oe <= 1'b1;
              2'd3: begin
                bus_open <= 1'b1;
                o_busy   <= 1'b0;
                o_done   <= 1'b1;
                state    <= S_DONE;
              end
            endcase
          end
          S_BIT: begin
            unique case (q)
              2'd0: o_scl_oe <= 1'b0;
              2'd1: ;
              2'd2: o_scl_oe <= 1'b1;
              2'd3: begin
                if (bit_idx == 3'd0) begin
                  state    <= S_ACK;
                  o_sda_oe <= 1'b0;
                end else begin
                  bit_idx  <= bit_idx - 3'd1;
                  shreg    <= {shreg[5:0], 1'b0};
                  o_sda_oe <= ~shreg[6];
                end
              end
            endcase
          end
          S_ACK: begin
            unique case (q)
              2'd0: o_scl_oe <= 1'b0;
              2'd1: ;
              2'd2: begin
                o_nack   <= i_sda;
                o_scl_oe <= 1'b1;
              end
              2'd3: begin
                o_busy <= 1'b0;
                o_done <= 1'b1;
                state  <= S_DONE;
              end
            endcase
          end
          S_STOP: begin
            unique case (q)
              2'd0: o_scl_oe <= 1'b0;
              2'd1: o_sda_oe <= 1'b0;
              2'd2: ;
              2'd3: begin
                bus_open <= 1'b0;
                o_busy   <= 1'b0;
                o_done   <= 1'b1;
                state    <= S_DONE;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_oled_master.sv
// tb_i2c_oled_master: phase-level model of the I2C primitives compared
// against the DUT every cycle, plus directed literal checks.
module tb_i2c_oled_master;

  localparam int DIV = 4;
  localparam logic [2:0] C_NOP     = 3'd0;
  localparam logic [2:0] C_START   = 3'd1;
  localparam logic [2:0] C_STOP    = 3'd2;
  localparam logic [2:0] C_SENDCON = 3'd3;
  localparam logic [2:0] C_SENDI2C = 3'd4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] i_cmd = 3'd0;
  logic       i_cmd_valid = 1'b0;
  logic [7:0] i_data = 8'd0;
  logic       i_sda = 1'b1;
  logic       o_scl_oe, o_sda_oe, o_busy, o_done, o_nack, o_err;

  always #5 clk = ~clk;

  i2c_oled_master #(
    .CLK_DIV   (DIV),
    .SLAVE_ADDR(7'h3C)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_cmd      (i_cmd),
    .i_cmd_valid(i_cmd_valid),
    .i_data     (i_data),
    .i_sda      (i_sda),
    .o_scl_oe   (o_scl_oe),
    .o_sda_oe   (o_sda_oe),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_nack     (o_nack),
    .o_err      (o_err)
  );

  typedef struct packed {
    logic scl;
    logic sda;
    logic busy;
    logic done;
    logic nack;
    logic err;
  } exp_t;

  exp_t exq[$];
  exp_t ce, ca;

  logic m_scl = 0, m_sda = 0, m_nack = 0, m_err = 0, m_open = 0;

  int checks = 0, errors = 0;
  int cyc = 0, busy_cnt = 0, done_cyc = -1, hi_chg = 0, t_acc = 0;
  logic       hi_fall = 1'b0;
  logic [8:0] wire_bits = '0;
  logic       prev_scl = 1'b0, prev_sda = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic busy, input logic done);
    exp_t t;
    t = '{m_scl, m_sda, busy, done, m_nack, m_err};
    return t;
  endfunction

  // One quarter phase: -1 leaves a line as it was.
  task automatic ph(input int scl, input int sda);
    if (scl >= 0) m_scl = scl[0];
    if (sda >= 0) m_sda = sda[0];
    repeat (DIV) exq.push_back(mk(1'b1, 1'b0));
  endtask

  task automatic model_cmd(input logic [2:0] cmd, input logic [7:0] data,
                           input logic resp);
    logic       legal;
    logic [7:0] b;
    legal = (cmd == C_START) || m_open;
    if (cmd == C_SENDCON || cmd == C_SENDI2C) m_nack = 1'b0;
    m_err = !legal;
    if (legal) begin
      if (cmd == C_START) begin
        ph(-1, 0); ph(0, -1); ph(-1, 1); ph(1, -1);
        m_open = 1'b1;
      end else if (cmd == C_STOP) begin
        ph(1, 1); ph(0, -1); ph(-1, 0); ph(-1, -1);
        m_open = 1'b0;
      end else begin
        b = (cmd == C_SENDCON) ? {7'h3C, 1'b0} : data;
        for (int i = 7; i >= 0; i--) begin
          ph(1, b[i] ? 0 : 1); ph(0, -1); ph(-1, -1); ph(1, -1);
        end
        ph(-1, 0); ph(0, -1); ph(-1, -1);
        m_nack = resp;
        ph(1, -1);
      end
    end
    exq.push_back(mk(1'b0, 1'b1));
  endtask

  always @(posedge clk) begin
    #1;
    cyc++;
    if (exq.size() != 0) ce = exq.pop_front();
    else ce = mk(1'b0, 1'b0);
    ca = '{o_scl_oe, o_sda_oe, o_busy, o_done, o_nack, o_err};
    checks++;
    if (ca !== ce) begin
      errors++;
      $display("FAIL cycle_%0d scl,sda,busy,done,nack,err got %b expected %b",
               cyc, ca, ce);
    end
    if (o_busy) busy_cnt++;
    if (o_done) done_cyc = cyc;
    if (prev_scl && !o_scl_oe) wire_bits = {wire_bits[7:0], ~o_sda_oe};
    if (!prev_scl && !o_scl_oe && (prev_sda != o_sda_oe)) begin
      hi_chg++;
      hi_fall = o_sda_oe;
    end
    prev_scl = o_scl_oe;
    prev_sda = o_sda_oe;
  end

  task automatic mon_clear();
    busy_cnt = 0; done_cyc = -1; hi_chg = 0; hi_fall = 1'b0;
    wire_bits = '0;
  endtask

  task automatic issue(input logic [2:0] cmd, input logic [7:0] data,
                       input logic resp, input bit modeled);
    @(negedge clk);
    i_cmd = cmd; i_data = data; i_sda = resp; i_cmd_valid = 1'b1;
    if (modeled) model_cmd(cmd, data, resp);
    @(posedge clk);
    #2 t_acc = cyc;
    @(negedge clk);
    i_cmd_valid = 1'b0; i_cmd = C_NOP;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300 && exq.size() != 0; i++) @(negedge clk);
    if (exq.size() != 0) begin
      checks++; errors++;
      $display("FAIL timeout: %0d expected cycles left, required 0",
               exq.size());
      exq.delete();
    end
  endtask

  task automatic do_cmd(input logic [2:0] cmd, input logic [7:0] data,
                        input logic resp, output int lat);
    int t0;
    issue(cmd, data, resp, 1'b1);
    t0 = t_acc;
    wait_idle();
    lat = done_cyc - t0 + 1;
  endtask

  initial begin
    int lat, t0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_scl", o_scl_oe, 0);
    chk("rst_sda", o_sda_oe, 0);
    chk("rst_status", {o_busy, o_done, o_nack, o_err}, 0);

    // 1: START from idle
    mon_clear();
    do_cmd(C_START, 8'h00, 1'b1, lat);
    chk("t1_busy_cycles", busy_cnt, 16);
    chk("t1_done_lat", lat, 17);
    chk("t1_sda_moves_hi", hi_chg, 1);
    chk("t1_sda_fall_hi", hi_fall, 1);
    chk("t1_scl_low", o_scl_oe, 1);
    chk("t1_err", o_err, 0);

    // 2: data byte A5 ACKed; a STOP offered while busy is ignored
    mon_clear();
    issue(C_SENDI2C, 8'hA5, 1'b0, 1'b1);
    t0 = t_acc;
    repeat (5) @(negedge clk);
    issue(C_STOP, 8'h00, 1'b0, 1'b0);
    wait_idle();
    chk("t2_done_lat", done_cyc - t0 + 1, 145);
    chk("t2_wire_byte", wire_bits[8:1], 8'hA5);
    chk("t2_sda_stable", hi_chg, 0);
    chk("t2_nack", o_nack, 0);

    // 3: repeated START, address byte NACKed
    do_cmd(C_START, 8'h00, 1'b1, lat);
    mon_clear();
    do_cmd(C_SENDCON, 8'h00, 1'b1, lat);
    chk("t3_wire_byte", wire_bits[8:1], 8'h78);
    chk("t3_nack", o_nack, 1);
    chk("t3_scl_low", o_scl_oe, 1);
    do_cmd(C_STOP, 8'h00, 1'b1, lat);

    // no-op codes are ignored
    mon_clear();
    issue(C_NOP, 8'h00, 1'b1, 1'b0);
    issue(3'b101, 8'h00, 1'b1, 1'b0);
    issue(3'b111, 8'h00, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    chk("nop_no_done", done_cyc, -1);

    // 4: send with the bus closed
    mon_clear();
    do_cmd(C_SENDI2C, 8'h3C, 1'b1, lat);
    chk("t4_done_lat", lat, 1);
    chk("t4_err", o_err, 1);
    chk("t4_no_busy", busy_cnt, 0);

    // 5: full transaction, then a stray STOP
    do_cmd(C_START, 8'h00, 1'b1, lat);
    chk("t5_err_clr", o_err, 0);
    do_cmd(C_SENDCON, 8'h00, 1'b0, lat);
    do_cmd(C_SENDI2C, 8'h00, 1'b0, lat);
    do_cmd(C_STOP, 8'h00, 1'b1, lat);
    chk("t5_lines", {o_scl_oe, o_sda_oe}, 0);
    do_cmd(C_STOP, 8'h00, 1'b1, lat);
    chk("t5_stop2_lat", lat, 1);
    chk("t5_stop2_err", o_err, 1);

    // 6: reset during a bit with SCL held low
    do_cmd(C_START, 8'h00, 1'b1, lat);
    issue(C_SENDI2C, 8'hFF, 1'b0, 1'b1);
    @(negedge clk);
    chk("t6_scl_low", o_scl_oe, 1);
    chk("t6_busy", o_busy, 1);
    rst_n = 1'b0;
    exq.delete();
    m_scl = 0; m_sda = 0; m_nack = 0; m_err = 0; m_open = 0;
    @(negedge clk);
    chk("t6_lines", {o_scl_oe, o_sda_oe}, 0);
    chk("t6_status", {o_busy, o_done, o_nack, o_err}, 0);
    rst_n = 1'b1;
    mon_clear();
    do_cmd(C_START, 8'h00, 1'b1, lat);
    chk("t6_start_lat", lat, 17);
    chk("t6_start_err", o_err, 0);
    chk("t6_start_scl", o_scl_oe, 1);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
